// File: rtl/mbscore_ifetch_if.sv
// Instruction memory read bus between the fetch unit (master) and the
// instruction memory (slave).
//   mem_req   master->slave  read request, held until mem_ack
//   mem_addr  master->slave  word-aligned read address
//   mem_ack   slave->master  read complete; rdata/err valid this cycle
//   mem_rdata slave->master  read data
//   mem_err   slave->master  bus error, qualified by mem_ack
interface mbscore_ifetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_err;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata, mem_err
  );
endinterface

// File: rtl/mbscore_ifetch.sv
// MBS core instruction fetch unit.
// Takes a PC + fetch request, runs a req/ack read on the instruction bus
// (wait states, timeout, bus-error and misalignment detection) and delivers
// the word to the instruction register with a one-cycle ir_ack strobe.
// Ports:
//   clk, rst          core clock, async active-high reset
//   fetch_en, pc_in   fetch request and address (sampled in IDLE only)
//   flush             redirect: discard the outstanding fetch result
//   fault_clr         clear sticky fault, return to IDLE
//   mem               instruction bus (master side)
//   inst_out, ir_ack  delivered instruction and its one-cycle strobe
//   busy              high while a bus request is outstanding (REQ/DROP)
//   fault, fault_code sticky fault: 01 misaligned, 10 timeout, 11 bus error
module mbscore_ifetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  flush,
  input  logic                  fault_clr,
  mbscore_ifetch_if.master      mem,
  output logic [DATA_WIDTH-1:0] inst_out,
  output logic                  ir_ack,
  output logic                  busy,
  output logic                  fault,
  output logic [1:0]            fault_code
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_ALIGN = 2'b01;
  localparam logic [1:0] FC_TOUT  = 2'b10;
  localparam logic [1:0] FC_BUS   = 2'b11;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          tout;

  // Saturating count of unacknowledged request cycles including this one;
  // reaching TIMEOUT means this was the TIMEOUT-th unacked cycle.
  assign cnt_nxt = (cnt == TO_VAL) ? cnt : cnt + CW'(1);
  assign tout    = (cnt_nxt == TO_VAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      inst_out     <= '0;
      ir_ack       <= 1'b0;
      busy         <= 1'b0;
      fault        <= 1'b0;
      fault_code   <= FC_NONE;
    end else begin
      ir_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          // flush is meaningless here; a concurrent fetch_en is accepted
          if (fetch_en) begin
            if (pc_in[1:0] == 2'b00) begin
              mem.mem_addr <= pc_in;
              cnt          <= '0;
              mem.mem_req  <= 1'b1;
              busy         <= 1'b1;
              state        <= S_REQ;
            end else begin
              fault      <= 1'b1;
              fault_code <= FC_ALIGN;
              state      <= S_FAULT;
            end
          end
        end

        S_REQ: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            busy        <= 1'b0;
            // A redirect makes the result irrelevant, including its error.
            if (flush) begin
              state <= S_IDLE;
            end else if (mem.mem_err) begin
              fault      <= 1'b1;
              fault_code <= FC_BUS;
              state      <= S_FAULT;
            end else begin
              inst_out <= mem.mem_rdata;
              ir_ack   <= 1'b1;
              state    <= S_IDLE;
            end
          end else begin
            cnt <= cnt_nxt;
            if (tout) begin
              mem.mem_req <= 1'b0;
              busy        <= 1'b0;
              fault       <= 1'b1;
              fault_code  <= FC_TOUT;
              state       <= S_FAULT;
            end else if (flush) begin
              // Request stays up until acked; DROP swallows the response.
              state <= S_DROP;
            end
          end
        end

        S_DROP: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt_nxt;
            if (tout) begin
              mem.mem_req <= 1'b0;
              busy        <= 1'b0;
              fault       <= 1'b1;
              fault_code  <= FC_TOUT;
              state       <= S_FAULT;
            end
          end
        end

        default: begin // S_FAULT
          if (fault_clr) begin
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            state      <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbscore_ifetch.sv
module tb_mbscore_ifetch;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_en;
  logic [AW-1:0] pc_in;
  logic          flush;
  logic          fault_clr;
  logic [DW-1:0] inst_out;
  logic          ir_ack;
  logic          busy;
  logic          fault;
  logic [1:0]    fault_code;

  int checks = 0;
  int errors = 0;

  mbscore_ifetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

  mbscore_ifetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc_in(pc_in),
    .flush(flush), .fault_clr(fault_clr), .mem(mem_bus.master),
    .inst_out(inst_out), .ir_ack(ir_ack), .busy(busy),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", mem_bus.mem_req); end
    checks++; if (mem_bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h exp 0", mem_bus.mem_addr); end
    checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h exp 0", inst_out); end
    checks++; if (ir_ack !== 1'b0) begin errors++; $display("FAIL rst_irack: got %b exp 0", ir_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b exp 0", fault); end
    checks++; if (fault_code !== 2'b00) begin errors++; $display("FAIL rst_code: got %b exp 00", fault_code); end
  endtask

  task automatic test_zero_wait();
    fetch_en = 1'b1; pc_in = 32'h0000_0040;               // cycle 0
    tick();                                               // cycle 1
    fetch_en = 1'b0;
    checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("FAIL zw_req: got %b exp 1", mem_bus.mem_req); end
    checks++; if (mem_bus.mem_addr !== 32'h40) begin errors++; $display("FAIL zw_addr: got %h exp 40", mem_bus.mem_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zw_busy: got %b exp 1", busy); end
    checks++; if (ir_ack !== 1'b0) begin errors++; $display("FAIL zw_irack_c1: got %b exp 0", ir_ack); end
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h2408_0005;
    tick();                                               // cycle 2
    mem_bus.mem_ack = 1'b0;
    checks++; if (ir_ack !== 1'b1) begin errors++; $display("FAIL zw_irack_c2: got %b exp 1", ir_ack); end
    checks++; if (inst_out !== 32'h2408_0005) begin errors++; $display("FAIL zw_inst: got %h exp 24080005", inst_out); end
    checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL zw_req_done: got %b exp 0", mem_bus.mem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zw_busy_done: got %b exp 0", busy); end
    tick();                                               // cycle 3
    checks++; if (ir_ack !== 1'b0) begin errors++; $display("FAIL zw_irack_c3: got %b exp 0", ir_ack); end
    checks++; if (inst_out !== 32'h2408_0005) begin errors++; $display("FAIL zw_inst_hold: got %h exp 24080005", inst_out); end
  endtask

  task automatic test_back_to_back();
    fetch_en = 1'b1; pc_in = 32'h0000_0040;               // cycle 0
    for (int c = 1; c <= 4; c++) begin
      tick();
      fetch_en = 1'b0;
      checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("FAIL b2b_req c%0d: got %b exp 1", c, mem_bus.mem_req); end
      checks++; if (mem_bus.mem_addr !== 32'h40) begin errors++; $display("FAIL b2b_addr c%0d: got %h exp 40", c, mem_bus.mem_addr); end
      checks++; if (ir_ack !== 1'b0) begin errors++; $display("FAIL b2b_irack c%0d: got %b exp 0", c, ir_ack); end
      if (c == 4) begin
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h1111_2222;
      end
    end
    tick();                                               // cycle 5
    mem_bus.mem_ack = 1'b0;
    checks++; if (ir_ack !== 1'b1) begin errors++; $display("FAIL b2b_irack_c5: got %b exp 1", ir_ack); end
    checks++; if (inst_out !== 32'h1111_2222) begin errors++; $display("FAIL b2b_inst1: got %h exp 11112222", inst_out); end
    fetch_en = 1'b1; pc_in = 32'h0000_0044;               // accepted in the ir_ack cycle
    tick();                                               // cycle 6
    fetch_en = 1'b0;
    checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("FAIL b2b_req2: got %b exp 1", mem_bus.mem_req); end
    checks++; if (mem_bus.mem_addr !== 32'h44) begin errors++; $display("FAIL b2b_addr2: got %h exp 44", mem_bus.mem_addr); end
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h3333_4444;
    tick();                                               // cycle 7
    mem_bus.mem_ack = 1'b0;
    checks++; if (ir_ack !== 1'b1) begin errors++; $display("FAIL b2b_irack2: got %b exp 1", ir_ack); end
    checks++; if (inst_out !== 32'h3333_4444) begin errors++; $display("FAIL b2b_inst2: got %h exp 33334444", inst_out); end
    tick();
  endtask

  task automatic test_flush();
    fetch_en = 1'b1; pc_in = 32'h0000_0080;               // cycle 0
    tick();                                               // cycle 1: wait 1
    fetch_en = 1'b0;
    tick();                                               // cycle 2: wait 2
    flush = 1'b1;
    tick();                                               // cycle 3: DROP
    flush = 1'b0;
    checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("FAIL fl_req_c3: got %b exp 1", mem_bus.mem_req); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fl_busy_c3: got %b exp 1", busy); end
    fetch_en = 1'b1; pc_in = 32'h0000_00C0;               // ignored in DROP
    tick();                                               // cycle 4
    fetch_en = 1'b0;
    checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("FAIL fl_req_c4: got %b exp 1", mem_bus.mem_req); end
    checks++; if (mem_bus.mem_addr !== 32'h80) begin errors++; $display("FAIL fl_addr_c4: got %h exp 80", mem_bus.mem_addr); end
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hDEAD_BEEF;
    tick();                                               // cycle 5
    mem_bus.mem_ack = 1'b0;
    checks++; if (ir_ack !== 1'b0) begin errors++; $display("FAIL fl_irack: got %b exp 0", ir_ack); end
    checks++; if (inst_out !== 32'h3333_4444) begin errors++; $display("FAIL fl_inst: got %h exp 33334444", inst_out); end
    checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL fl_req_done: got %b exp 0", mem_bus.mem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fl_busy_done: got %b exp 0", busy); end
    tick();
    checks++; if (ir_ack !== 1'b0) begin errors++; $display("FAIL fl_irack_late: got %b exp 0", ir_ack); end
    checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL fl_idle_req: got %b exp 0", mem_bus.mem_req); end
  endtask

  task automatic test_misaligned();
    fetch_en = 1'b1; pc_in = 32'h0000_0042;
    tick();
    checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b exp 0", mem_bus.mem_req); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL mis_fault: got %b exp 1", fault); end
    checks++; if (fault_code !== 2'b01) begin errors++; $display("FAIL mis_code: got %b exp 01", fault_code); end
    pc_in = 32'h0000_0040;                                // aligned fetch still ignored
    tick();
    tick();
    fetch_en = 1'b0;
    checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL mis_ign_req: got %b exp 0", mem_bus.mem_req); end
    checks++; if (fault_code !== 2'b01) begin errors++; $display("FAIL mis_hold: got %b exp 01", fault_code); end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL mis_clr_fault: got %b exp 0", fault); end
    checks++; if (fault_code !== 2'b00) begin errors++; $display("FAIL mis_clr_code: got %b exp 00", fault_code); end
  endtask

  task automatic test_timeout();
    fetch_en = 1'b1; pc_in = 32'h0000_0100;
    for (int c = 1; c <= 4; c++) begin
      tick();
      fetch_en = 1'b0;
      checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("FAIL to_req c%0d: got %b exp 1", c, mem_bus.mem_req); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL to_early c%0d: got %b exp 0", c, fault); end
    end
    tick();                                               // cycle 5
    checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL to_req_drop: got %b exp 0", mem_bus.mem_req); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL to_fault: got %b exp 1", fault); end
    checks++; if (fault_code !== 2'b10) begin errors++; $display("FAIL to_code: got %b exp 10", fault_code); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b exp 0", busy); end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL to_clr: got %b exp 0", fault); end
  endtask

  task automatic test_bus_err();
    fetch_en = 1'b1; pc_in = 32'h0000_000C;
    tick();
    fetch_en = 1'b0;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_err = 1'b1; mem_bus.mem_rdata = 32'h5555_AAAA;
    tick();
    mem_bus.mem_ack = 1'b0; mem_bus.mem_err = 1'b0;
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL be_fault: got %b exp 1", fault); end
    checks++; if (fault_code !== 2'b11) begin errors++; $display("FAIL be_code: got %b exp 11", fault_code); end
    checks++; if (ir_ack !== 1'b0) begin errors++; $display("FAIL be_irack: got %b exp 0", ir_ack); end
    checks++; if (inst_out !== 32'h3333_4444) begin errors++; $display("FAIL be_inst: got %h exp 33334444", inst_out); end
    checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL be_req: got %b exp 0", mem_bus.mem_req); end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++; if (fault_code !== 2'b00) begin errors++; $display("FAIL be_clr: got %b exp 00", fault_code); end
  endtask

  task automatic test_rst_mid();
    fetch_en = 1'b1; pc_in = 32'h0000_0020;
    tick();
    fetch_en = 1'b0;
    checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("FAIL rm_req_pre: got %b exp 1", mem_bus.mem_req); end
    #2 rst = 1'b1;                                        // between edges
    #1;
    checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL rm_req_async: got %b exp 0", mem_bus.mem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy_async: got %b exp 0", busy); end
    checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL rm_inst: got %h exp 0", inst_out); end
    tick();
    rst = 1'b0;
    // flush alongside fetch_en in IDLE: fetch is still accepted
    fetch_en = 1'b1; flush = 1'b1; pc_in = 32'h0000_0000;
    tick();
    fetch_en = 1'b0; flush = 1'b0;
    checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("FAIL rm_req_new: got %b exp 1", mem_bus.mem_req); end
    checks++; if (mem_bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rm_addr_new: got %h exp 0", mem_bus.mem_addr); end
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hA5A5_0001;
    tick();
    mem_bus.mem_ack = 1'b0;
    checks++; if (ir_ack !== 1'b1) begin errors++; $display("FAIL rm_irack: got %b exp 1", ir_ack); end
    checks++; if (inst_out !== 32'hA5A5_0001) begin errors++; $display("FAIL rm_inst_new: got %h exp a5a50001", inst_out); end
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; pc_in = '0; flush = 1'b0; fault_clr = 1'b0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0; mem_bus.mem_err = 1'b0;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_zero_wait();
    test_back_to_back();
    test_flush();
    test_misaligned();
    test_timeout();
    test_bus_err();
    test_rst_mid();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
